// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder for the MEM
// stage. It accepts one request at a time, does big-endian sub-word stores
// into a local word array, and returns aligned, sign/zero-extended load data
// after a fixed read latency. Busy feeds the pipeline hazard logic.
module data_mem_responder #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        AlignErr,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    logic [31:0]       mem [0:(2**ADDR_W)-1];

    state_t            state, state_next;
    logic [3:0]        count, count_next;
    logic [31:0]       hold_data, hold_data_next;
    logic              hold_err, hold_err_next;

    logic              accept;
    logic              is_half, is_byte, misaligned;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [31:0]       load_val;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    // Bits above the word index alias onto the same array entries.
    wire unused_addr_bits = &{1'b0, ReqAddr[31:ADDR_W+2]};

    assign ReqReady  = (state == IDLE) & ~Reset;
    assign accept    = ReqValid & ReqReady;
    assign word_idx  = ReqAddr[ADDR_W+1:2];
    assign lane      = ReqAddr[1:0];
    assign rd_word   = mem[word_idx];

    assign RespValid = (state == RESP);
    assign RespData  = RespValid ? hold_data : 32'd0;
    assign AlignErr  = RespValid & hold_err;
    assign Busy      = (state != IDLE);

    // Decode access size, alignment and the byte-lane write pattern (size 11 acts as word).
    always_comb begin
        is_half    = (ReqSize == 2'b01);
        is_byte    = (ReqSize == 2'b10);
        misaligned = 1'b0;
        wr_be      = 4'b1111;
        wr_data    = ReqWData;
        if (is_half) begin
            misaligned = lane[0];
            wr_be      = lane[1] ? 4'b0011 : 4'b1100;
            wr_data    = {ReqWData[15:0], ReqWData[15:0]};
        end else if (is_byte) begin
            wr_be      = 4'b1000 >> lane;
            wr_data    = {4{ReqWData[7:0]}};
        end else begin
            misaligned = (lane != 2'b00);
        end
    end

    // Pick the addressed big-endian lane and right-justify it with extension.
    always_comb begin
        half_sel = lane[1] ? rd_word[15:0] : rd_word[31:16];
        case (lane)
            2'd0:    byte_sel = rd_word[31:24];
            2'd1:    byte_sel = rd_word[23:16];
            2'd2:    byte_sel = rd_word[15:8];
            default: byte_sel = rd_word[7:0];
        endcase
        load_val = rd_word;
        if (is_half)
            load_val = {{16{ReqSigned & half_sel[15]}}, half_sel};
        else if (is_byte)
            load_val = {{24{ReqSigned & byte_sel[7]}}, byte_sel};
    end

    // Commit aligned stores on the acceptance edge, touching only enabled lanes.
    always_ff @(posedge Clk) begin
        if (accept && ReqWrite && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i])
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // State, latency counter and response holding registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            hold_data <= 32'd0;
            hold_err  <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            hold_data <= hold_data_next;
            hold_err  <= hold_err_next;
        end
    end

    // Next-state logic: errors and stores respond next cycle, loads wait out the latency.
    always_comb begin
        state_next     = state;
        count_next     = count;
        hold_data_next = hold_data;
        hold_err_next  = hold_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_next     = RESP;
                        hold_data_next = 32'd0;
                        hold_err_next  = 1'b1;
                    end else if (ReqWrite) begin
                        state_next     = RESP;
                        hold_data_next = 32'd0;
                        hold_err_next  = 1'b0;
                    end else begin
                        hold_data_next = load_val;
                        hold_err_next  = 1'b0;
                        if (READ_LATENCY == 1) begin
                            state_next = RESP;
                        end else begin
                            state_next = RD_WAIT;
                            count_next = LAT_M1;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (count == 4'd1) begin
                    state_next = RESP;
                    count_next = 4'd0;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder
// (ADDR_W=10, READ_LATENCY=2) with hand-computed expected values.
module tb_data_mem_responder;

    logic        Clk;
    logic        Reset;
    logic        ReqValid;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        ReqReady;
    logic        RespValid;
    logic [31:0] RespData;
    logic        AlignErr;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(
        .ADDR_W       (10),
        .READ_LATENCY (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqWrite  (ReqWrite),
        .ReqSize   (ReqSize),
        .ReqSigned (ReqSigned),
        .ReqAddr   (ReqAddr),
        .ReqWData  (ReqWData),
        .ReqReady  (ReqReady),
        .RespValid (RespValid),
        .RespData  (RespData),
        .AlignErr  (AlignErr),
        .Busy      (Busy)
    );

    // Free-running 10-unit clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one request, then measure response latency (in negedges after acceptance) and Busy cycles.
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic [31:0] data, output logic err,
                                 output int lat, output int busyCycles);
        @(negedge Clk);
        ReqWrite  = w;
        ReqSize   = sz;
        ReqSigned = sg;
        ReqAddr   = addr;
        ReqWData  = wd;
        ReqValid  = 1'b1;
        checkOutput("ready_before_accept", {31'd0, ReqReady}, 32'd1);
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        lat        = 99;
        busyCycles = 0;
        data       = 32'hxxxxxxxx;
        err        = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (Busy) busyCycles++;
            if (RespValid) begin
                lat  = i;
                data = RespData;
                err  = AlignErr;
                break;
            end
        end
    endtask

    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] expData, input logic expErr, input int expLat);
        logic [31:0] d;
        logic        e;
        int          l;
        int          b;
        applyStimulus(w, sz, sg, addr, wd, d, e, l, b);
        checkOutput({tag, "_lat"}, l, expLat);
        checkOutput({tag, "_data"}, d, expData);
        checkOutput({tag, "_err"}, {31'd0, e}, {31'd0, expErr});
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          l;
        int          b;
        int          acc[$];
        int          respCount;

        Reset     = 1'b1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqSize   = 2'b00;
        ReqSigned = 1'b0;
        ReqAddr   = 32'd0;
        ReqWData  = 32'd0;
        repeat (3) @(negedge Clk);
        checkOutput("rst_ready", {31'd0, ReqReady}, 32'd0);
        checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_respvalid", {31'd0, RespValid}, 32'd0);
        checkOutput("rst_respdata", RespData, 32'd0);
        checkOutput("rst_alignerr", {31'd0, AlignErr}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("ready_after_rst", {31'd0, ReqReady}, 32'd1);

        // Word store then word load with latency and Busy duration.
        access("st_w_10", 1'b1, 2'b00, 1'b0, 32'h10, 32'h11223344, 32'd0, 1'b0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, d, e, l, b);
        checkOutput("ld_w_10_lat", l, 2);
        checkOutput("ld_w_10_data", d, 32'h11223344);
        checkOutput("ld_w_10_busy", b, 2);

        // Signed and unsigned byte loads.
        access("st_w_f2", 1'b1, 2'b00, 1'b0, 32'h10, 32'h11F23344, 32'd0, 1'b0, 1);
        access("ld_b_s", 1'b0, 2'b10, 1'b1, 32'h11, 32'd0, 32'hFFFFFFF2, 1'b0, 2);
        access("ld_b_u", 1'b0, 2'b10, 1'b0, 32'h11, 32'd0, 32'h000000F2, 1'b0, 2);

        // Sub-word stores merge into the existing word.
        access("st_w_re", 1'b1, 2'b00, 1'b0, 32'h10, 32'h11223344, 32'd0, 1'b0, 1);
        access("st_b_13", 1'b1, 2'b10, 1'b0, 32'h13, 32'hFFFFFFAB, 32'd0, 1'b0, 1);
        access("ld_after_b", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'h112233AB, 1'b0, 2);
        access("st_h_10", 1'b1, 2'b01, 1'b0, 32'h10, 32'h1234BEEF, 32'd0, 1'b0, 1);
        access("ld_after_h", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'hBEEF33AB, 1'b0, 2);
        access("ld_h_hi_s", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'hFFFFBEEF, 1'b0, 2);
        access("ld_h_lo_s", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 32'h000033AB, 1'b0, 2);
        access("ld_b_3_u", 1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 32'h000000AB, 1'b0, 2);
        access("ld_size11", 1'b0, 2'b11, 1'b1, 32'h10, 32'd0, 32'hBEEF33AB, 1'b0, 2);

        // Misaligned requests respond with an error and leave the array alone.
        access("ld_w_mis", 1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 32'd0, 1'b1, 1);
        access("st_h_mis", 1'b1, 2'b01, 1'b0, 32'h11, 32'h00005555, 32'd0, 1'b1, 1);
        access("st_w_mis", 1'b1, 2'b11, 1'b0, 32'h13, 32'h77777777, 32'd0, 1'b1, 1);
        access("ld_after_mis", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'hBEEF33AB, 1'b0, 2);

        // Reset during RD_WAIT aborts the load; reset on an acceptance edge blocks the store.
        @(negedge Clk);
        ReqWrite = 1'b0;
        ReqSize  = 2'b00;
        ReqAddr  = 32'h10;
        ReqValid = 1'b1;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        @(negedge Clk);
        checkOutput("rdwait_busy", {31'd0, Busy}, 32'd1);
        Reset    = 1'b1;
        ReqWrite = 1'b1;
        ReqWData = 32'hDEADBEEF;
        ReqValid = 1'b1;
        @(negedge Clk);
        checkOutput("abort_respvalid", {31'd0, RespValid}, 32'd0);
        checkOutput("abort_busy", {31'd0, Busy}, 32'd0);
        checkOutput("abort_ready", {31'd0, ReqReady}, 32'd0);
        @(negedge Clk);
        checkOutput("abort_respvalid2", {31'd0, RespValid}, 32'd0);
        checkOutput("abort_busy2", {31'd0, Busy}, 32'd0);
        Reset    = 1'b0;
        ReqValid = 1'b0;
        @(negedge Clk);
        checkOutput("ready_after_abort", {31'd0, ReqReady}, 32'd1);
        access("ld_after_abort", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'hBEEF33AB, 1'b0, 2);

        // Higher address bits alias onto the same word.
        access("st_w_0", 1'b1, 2'b00, 1'b0, 32'h0, 32'hCAFEF00D, 32'd0, 1'b0, 1);
        access("ld_alias", 1'b0, 2'b00, 1'b0, 32'h1000, 32'd0, 32'hCAFEF00D, 1'b0, 2);

        // ReqValid held high: acceptances every READ_LATENCY+1 cycles.
        @(negedge Clk);
        ReqWrite  = 1'b0;
        ReqSize   = 2'b00;
        ReqAddr   = 32'h1000;
        ReqValid  = 1'b1;
        respCount = 0;
        for (int c = 0; c < 12; c++) begin
            if (ReqReady) acc.push_back(c);
            if (RespValid) begin
                respCount++;
                checkOutput("stream_data", RespData, 32'hCAFEF00D);
            end
            @(negedge Clk);
        end
        ReqValid = 1'b0;
        checkOutput("stream_accepts", acc.size(), 4);
        checkOutput("stream_resps", respCount, 4);
        if (acc.size() >= 4) begin
            checkOutput("stream_gap01", acc[1] - acc[0], 3);
            checkOutput("stream_gap23", acc[3] - acc[2], 3);
        end
        repeat (4) @(negedge Clk);
        checkOutput("final_idle", {31'd0, Busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's load/store port: accepts one request at a time over a valid/ready handshake and returns aligned, extended load data after a fixed latency.
- Performs sub-word stores via byte-lane writes into an internal word array.
- Sits between the MEM stage and the data storage. Its Busy output feeds the hazard logic so the pipeline stalls while an access is in flight.

Parameters:
- ADDR_W, 10, word-index width; array holds 2**ADDR_W 32-bit words.
- READ_LATENCY, 2, cycles from read acceptance to RespValid. Legal range 1..15.

Ports:
- Clk  input  1  clock
- Reset  input  1  synchronous, active-high reset
- ReqValid  input  1  request present
- ReqWrite  input  1  1=store, 0=load
- ReqSize  input  2  00=word, 01=halfword, 10=byte, 11=treated as word
- ReqSigned  input  1  loads only: 1=sign-extend, 0=zero-extend
- ReqAddr  input  32  byte address
- ReqWData  input  32  store data; low byte/half used for sub-word stores
- ReqReady  output  1  responder can accept this cycle
- RespValid  output  1  one-cycle completion pulse
- RespData  output  32  load result; 0 for stores and errors
- AlignErr  output  1  qualifies RespValid: misaligned request
- Busy  output  1  access in flight; drives pipeline stall

Behaviour:
- Clock and reset: single clock Clk; Reset is synchronous and active-high.
- Reset values: state IDLE, counter 0, ReqReady=0 while Reset is high, RespValid=0, RespData=0, AlignErr=0, Busy=0. Array contents are not reset.
- Handshake: a request is accepted on a rising edge where ReqValid&ReqReady=1. ReqReady = (state==IDLE) & ~Reset. Inputs are don't-care when not accepted. Only one request is outstanding; no pipelining.
- Address: word index = ReqAddr[ADDR_W+1:2]; higher bits are ignored (aliasing wraps modulo array size). Lane select = ReqAddr[1:0]. Big-endian: byte 0 is bits[31:24]; half 0 is bits[31:16].
- Alignment: a word with ReqAddr[1:0]!=0, or a halfword with ReqAddr[0]=1, is misaligned.
  - No array access occurs.
  - The response is the cycle after acceptance: RespValid=1, AlignErr=1, RespData=0.
- States: IDLE, RD_WAIT, RESP.
  - IDLE -> RD_WAIT on an aligned accepted load when READ_LATENCY>1. The counter loads READ_LATENCY-1. The word is read and the selected lane is extracted/extended into a holding register at acceptance.
  - IDLE -> RESP on an accepted store (the array is written at the acceptance edge), on a misaligned request, or on a load when READ_LATENCY==1.
  - RD_WAIT: the counter decrements each cycle; -> RESP when the counter reaches 1.
  - RESP: RespValid=1 for exactly one cycle, then -> IDLE. ReqReady is high again the following cycle.
- Latency:
  - Aligned load: RespValid is high exactly READ_LATENCY cycles after the acceptance edge.
  - Store or error: 1 cycle.
  - Back-to-back minimum spacing: READ_LATENCY+1 cycles for loads, 2 for stores.
- Stores: word writes all 4 lanes. Halfword writes ReqWData[15:0] into the half chosen by ReqAddr[1]. Byte writes ReqWData[7:0] into the lane chosen by ReqAddr[1:0]. Other lanes are unchanged. Store response: RespData=0, AlignErr=0.
- Loads: the selected lane is right-justified in RespData; upper bits are sign- or zero-extended per ReqSigned. Word loads ignore ReqSigned.
- Output timing: RespData and AlignErr are registered, valid only while RespValid=1, and forced to 0 otherwise.
- Busy = (state!=IDLE).
- Reset mid-operation: the in-flight read is aborted with no RespValid, and the state returns to IDLE. A store already accepted has already committed. Reset on the acceptance edge wins: nothing is accepted and nothing is written.
- Read-after-write to the same word in consecutive accepted requests returns the new data.
- ReqSize=11 behaves identically to 00.

Test Plan:
- Store word 0x11223344 @0x10, then load word @0x10 (READ_LATENCY=2) -> RespValid exactly 2 cycles after acceptance, RespData=0x11223344, Busy high for 2 cycles.
- Load byte @0x11 with ReqSigned=1 after storing 0x11F23344 @0x10 -> RespData=0xFFFFFFF2. The same load with ReqSigned=0 -> 0x000000F2.
- Store byte 0xAB @0x13 over word 0x11223344 -> a word load @0x10 returns 0x112233AB. Store half 0xBEEF @0x10 -> 0xBEEF33AB.
- Load word @0x12 -> RespValid 1 cycle after acceptance, AlignErr=1, RespData=0. Array unchanged (verify with a follow-up load).
- Assert Reset during RD_WAIT of a load @0x10 -> no RespValid; Busy=0 and ReqReady=0 while Reset is high; ReqReady=1 the cycle after Reset deasserts; the next load @0x10 returns the pre-reset contents.
- Alias check (ADDR_W=10): store 0xCAFEF00D @0x0 -> load @0x1000 returns 0xCAFEF00D. ReqValid held high continuously -> acceptances spaced READ_LATENCY+1 cycles apart.
